// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-stream round-robin arbiter.
// Pure combinational functions; no state lives here.
package mem_arb_pkg;

  typedef logic [5:0] atop_t;

  localparam int unsigned MaxReq  = 32;
  localparam int unsigned MaxReqW = 5;

  // Index width for n requesters, never zero so a 1-bit idx_t always exists.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit of req at or after ptr, wrapping at num; 0 when req is empty.
  function automatic int unsigned rr_pick(input logic [MaxReq-1:0] req,
                                          input int unsigned       ptr,
                                          input int unsigned       num);
    int unsigned pick;
    int unsigned j;
    logic        found;
    pick  = 0;
    found = 1'b0;
    for (int unsigned k = 0; k < MaxReq; k++) begin
      if (k < num && !found) begin
        j = ptr + k;
        if (j >= num) j = j - num;
        if (req[j[MaxReqW-1:0]]) begin
          found = 1'b1;
          pick  = j;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mem_stream_rr_arbiter_if.sv
// Requester-side and bank-side memory-stream signals of the arbiter.
// slave is the arbiter's view; master is the environment (requesters + bank).
interface mem_stream_rr_arbiter_if #(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64
);

  logic [NumReq-1:0]               req_i;
  logic [NumReq-1:0]               gnt_o;
  logic [NumReq*AddrWidth-1:0]     addr_i;
  logic [NumReq*DataWidth-1:0]     wdata_i;
  logic [NumReq*DataWidth/8-1:0]   strb_i;
  logic [NumReq*6-1:0]             atop_i;
  logic [NumReq-1:0]               we_i;
  logic [NumReq-1:0]               rvalid_o;
  logic [NumReq*DataWidth-1:0]     rdata_o;

  logic                            mem_req_o;
  logic                            mem_gnt_i;
  logic [AddrWidth-1:0]            mem_addr_o;
  logic [DataWidth-1:0]            mem_wdata_o;
  logic [DataWidth/8-1:0]          mem_strb_o;
  logic [5:0]                      mem_atop_o;
  logic                            mem_we_o;
  logic                            mem_rvalid_i;
  logic [DataWidth-1:0]            mem_rdata_i;

  modport slave (
    input  req_i, addr_i, wdata_i, strb_i, atop_i, we_i,
    output gnt_o, rvalid_o, rdata_o,
    output mem_req_o, mem_addr_o, mem_wdata_o, mem_strb_o, mem_atop_o, mem_we_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport master (
    output req_i, addr_i, wdata_i, strb_i, atop_i, we_i,
    input  gnt_o, rvalid_o, rdata_o,
    input  mem_req_o, mem_addr_o, mem_wdata_o, mem_strb_o, mem_atop_o, mem_we_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

endinterface

// File: rtl/mem_arb_route_fifo.sv
// Route FIFO of granted requester indices; head visible combinationally, 1-cycle write.
// Push is dropped when full (no same-cycle pop bypass), pop is dropped when empty.
module mem_arb_route_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 1,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_dat_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o,
  output logic [Width-1:0] head_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      // Push and pop together leave the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_stream_rr_arbiter.sv
// Round-robin share of one memory-stream bank port; zero-latency grant and response routing.
// Stops requesting when MaxOutst requests are unanswered; responses go back in issue order.
module mem_stream_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned MaxOutst  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  output logic                    busy_o,
  output logic                    err_o,
  mem_stream_rr_arbiter_if.slave  bus
);

  localparam int unsigned IdxW  = idx_width(NumReq);
  localparam int unsigned CntW  = $clog2(MaxOutst + 1);
  localparam int unsigned StrbW = DataWidth / 8;

  typedef logic [IdxW-1:0] idx_t;

  idx_t            rr_ptr_q;
  idx_t            winner;
  idx_t            head;
  logic            full;
  logic            empty;
  logic [CntW-1:0] count;
  logic            can_issue;
  logic            handshake;
  logic            pop;
  logic            err_q;

  assign winner    = idx_t'(rr_pick(MaxReq'(bus.req_i), 32'(rr_ptr_q), NumReq));
  assign can_issue = !full;
  assign handshake = bus.mem_req_o && bus.mem_gnt_i;
  assign pop       = bus.mem_rvalid_i && !empty;

  assign bus.mem_req_o = can_issue && (|bus.req_i);

  // Constant-index mux keeps the payload select free of variable part-selects.
  always_comb begin
    bus.mem_addr_o  = bus.addr_i[AddrWidth-1:0];
    bus.mem_wdata_o = bus.wdata_i[DataWidth-1:0];
    bus.mem_strb_o  = bus.strb_i[StrbW-1:0];
    bus.mem_atop_o  = bus.atop_i[5:0];
    bus.mem_we_o    = bus.we_i[0];
    for (int i = 1; i < NumReq; i++) begin
      if (winner == idx_t'(i)) begin
        bus.mem_addr_o  = bus.addr_i[i*AddrWidth +: AddrWidth];
        bus.mem_wdata_o = bus.wdata_i[i*DataWidth +: DataWidth];
        bus.mem_strb_o  = bus.strb_i[i*StrbW +: StrbW];
        bus.mem_atop_o  = atop_t'(bus.atop_i[i*6 +: 6]);
        bus.mem_we_o    = bus.we_i[i];
      end
    end
  end

  always_comb begin
    bus.gnt_o    = '0;
    bus.rvalid_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      bus.gnt_o[i]    = handshake && (winner == idx_t'(i));
      bus.rvalid_o[i] = pop && (head == idx_t'(i));
    end
  end

  assign bus.rdata_o = {NumReq{bus.mem_rdata_i}};

  mem_arb_route_fifo #(
    .Depth (MaxOutst),
    .Width (IdxW)
  ) i_route_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (handshake),
    .push_dat_i (winner),
    .pop_i      (pop),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (count),
    .head_o     (head)
  );

  // Pointer moves past the winner only on an accepted request, so a stalled bank holds priority.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
    end else if (handshake) begin
      rr_ptr_q <= (winner == idx_t'(NumReq - 1)) ? '0 : winner + idx_t'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (bus.mem_rvalid_i && empty) begin
      err_q <= 1'b1;
    end
  end

  assign err_o  = err_q;
  assign busy_o = (count != '0);

endmodule

// File: tb/tb_mem_stream_rr_arbiter.sv
// Scenario bench for mem_stream_rr_arbiter with a negedge scoreboard of granted indices.
module tb_mem_stream_rr_arbiter;

  localparam int unsigned NumReq    = 3;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned MaxOutst  = 2;
  localparam int unsigned StrbW     = DataWidth / 8;

  logic clk_i = 1'b0;
  logic rst_i;
  logic busy_o;
  logic err_o;

  int checks = 0;
  int errors = 0;

  int   route_q[$];
  int   m_ptr = 0;
  logic m_err = 1'b0;

  mem_stream_rr_arbiter_if #(
    .NumReq    (NumReq),
    .AddrWidth (AddrWidth),
    .DataWidth (DataWidth)
  ) bus ();

  mem_stream_rr_arbiter #(
    .NumReq    (NumReq),
    .AddrWidth (AddrWidth),
    .DataWidth (DataWidth),
    .MaxOutst  (MaxOutst)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .busy_o (busy_o),
    .err_o  (err_o),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard: reference arbitration model, pushes granted indices and pops on responses.
  always @(negedge clk_i) begin : scoreboard
    int                win;
    int                j;
    int                h;
    logic              found;
    logic              exp_req;
    logic              spurious;
    logic [NumReq-1:0] exp_gnt;
    logic [NumReq-1:0] exp_rv;
    if (rst_i) begin
      route_q.delete();
      m_ptr = 0;
      m_err = 1'b0;
      checks++;
      if (busy_o !== 1'b0 || err_o !== 1'b0 || bus.rvalid_o !== '0) begin
        errors++;
        $display("FAIL sb_reset: busy=%b err=%b rvalid=%b, required 0 0 0", busy_o, err_o, bus.rvalid_o);
      end
    end else begin
      win   = 0;
      found = 1'b0;
      for (int k = 0; k < NumReq; k++) begin
        j = (m_ptr + k) % NumReq;
        if (!found && bus.req_i[j]) begin
          found = 1'b1;
          win   = j;
        end
      end
      exp_req = (route_q.size() < MaxOutst) && (|bus.req_i);
      exp_gnt = '0;
      if (exp_req && bus.mem_gnt_i) exp_gnt[win] = 1'b1;

      checks++;
      if (bus.mem_req_o !== exp_req || bus.gnt_o !== exp_gnt) begin
        errors++;
        $display("FAIL sb_grant t=%0t: mem_req=%b gnt=%b, required %b %b", $time, bus.mem_req_o, bus.gnt_o, exp_req, exp_gnt);
      end
      checks++;
      if (bus.mem_addr_o !== bus.addr_i[win*AddrWidth +: AddrWidth] ||
          bus.mem_wdata_o !== bus.wdata_i[win*DataWidth +: DataWidth] ||
          bus.mem_strb_o !== bus.strb_i[win*StrbW +: StrbW] ||
          bus.mem_we_o !== bus.we_i[win]) begin
        errors++;
        $display("FAIL sb_payload t=%0t: addr=%h we=%b, required payload of requester %0d (addr %h)", $time, bus.mem_addr_o, bus.mem_we_o, win, bus.addr_i[win*AddrWidth +: AddrWidth]);
      end
      checks++;
      if (busy_o !== (route_q.size() != 0) || err_o !== m_err) begin
        errors++;
        $display("FAIL sb_status t=%0t: busy=%b err=%b, required %b %b", $time, busy_o, err_o, route_q.size() != 0, m_err);
      end

      exp_rv   = '0;
      spurious = 1'b0;
      if (bus.mem_rvalid_i) begin
        if (route_q.size() > 0) begin
          h = route_q.pop_front();
          exp_rv[h] = 1'b1;
          checks++;
          if (bus.rdata_o[h*DataWidth +: DataWidth] !== bus.mem_rdata_i) begin
            errors++;
            $display("FAIL sb_rdata t=%0t: rdata[%0d]=%h, required %h", $time, h, bus.rdata_o[h*DataWidth +: DataWidth], bus.mem_rdata_i);
          end
        end else begin
          spurious = 1'b1;
        end
      end
      checks++;
      if (bus.rvalid_o !== exp_rv) begin
        errors++;
        $display("FAIL sb_rvalid t=%0t: rvalid=%b, required %b", $time, bus.rvalid_o, exp_rv);
      end

      if (exp_gnt != '0) begin
        route_q.push_back(win);
        m_ptr = (win + 1) % NumReq;
      end
      if (spurious) m_err = 1'b1;
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_payload();
    for (int i = 0; i < NumReq; i++) begin
      bus.addr_i[i*AddrWidth +: AddrWidth]  = 32'h1000 + 32'(i) * 32'h100;
      bus.wdata_i[i*DataWidth +: DataWidth] = {32'hA5A5_0000 + 32'(i), 32'h0BAD_F00D ^ 32'(i)};
      bus.strb_i[i*StrbW +: StrbW]          = 8'hF0 | 8'(i);
      bus.atop_i[i*6 +: 6]                  = 6'(i);
    end
  endtask

  task automatic do_reset();
    rst_i            = 1'b1;
    bus.req_i        = '0;
    bus.we_i         = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    cyc();
    cyc();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    bus.req_i = 3'b011; bus.mem_gnt_i = 1'b1;
    cyc();
    cyc();
    bus.req_i = '0; bus.mem_gnt_i = 1'b0; rst_i = 1'b1;
    #3;
    checks++;
    if (bus.gnt_o !== '0 || bus.rvalid_o !== '0 || busy_o !== 1'b0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: gnt=%b rvalid=%b busy=%b err=%b, required all 0", bus.gnt_o, bus.rvalid_o, busy_o, err_o);
    end
    cyc();
    cyc();
    rst_i = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 64'h1111;
    #3;
    checks++;
    if (bus.rvalid_o !== '0) begin
      errors++;
      $display("FAIL reset_late_rvalid: rvalid=%b, required 000", bus.rvalid_o);
    end
    cyc();
    bus.mem_rvalid_i = 1'b0;
    bus.req_i = 3'b011; bus.mem_gnt_i = 1'b1;
    #3;
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_late_err: err=%b, required 1", err_o);
    end
    checks++;
    if (bus.gnt_o !== 3'b001) begin
      errors++;
      $display("FAIL reset_first_grant: gnt=%b, required 001", bus.gnt_o);
    end
    cyc();
    bus.req_i = '0; bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 64'h2222;
    #3;
    checks++;
    if (bus.rvalid_o !== 3'b001) begin
      errors++;
      $display("FAIL reset_resp: rvalid=%b, required 001", bus.rvalid_o);
    end
    cyc();
    bus.mem_rvalid_i = 1'b0;
  endtask

  task automatic test_fairness();
    logic [NumReq-1:0] exp;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      bus.req_i = 3'b111; bus.mem_gnt_i = 1'b1;
      bus.mem_rvalid_i = (k > 0);
      bus.mem_rdata_i  = 64'hF000 + 64'(k);
      exp = 3'b001 << (k % 3);
      #3;
      checks++;
      if (bus.gnt_o !== exp) begin
        errors++;
        $display("FAIL fair_grant_%0d: gnt=%b, required %b", k, bus.gnt_o, exp);
      end
      cyc();
    end
    bus.req_i = '0; bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1;
    cyc();
    bus.mem_rvalid_i = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.req_i = 3'b001; bus.mem_gnt_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #3;
      checks++;
      if (bus.mem_req_o !== 1'b1 || bus.gnt_o !== 3'b001) begin
        errors++;
        $display("FAIL bp_grant_%0d: mem_req=%b gnt=%b, required 1 001", k, bus.mem_req_o, bus.gnt_o);
      end
      cyc();
    end
    #3;
    checks++;
    if (bus.mem_req_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_full: mem_req=%b busy=%b, required 0 1", bus.mem_req_o, busy_o);
    end
    cyc();
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 64'h3333;
    #3;
    checks++;
    if (bus.mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_bypass: mem_req=%b, required 0", bus.mem_req_o);
    end
    cyc();
    bus.mem_rvalid_i = 1'b0; bus.mem_gnt_i = 1'b0;
    #3;
    checks++;
    if (bus.mem_req_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_reissue: mem_req=%b, required 1", bus.mem_req_o);
    end
    cyc();
    bus.req_i = '0; bus.mem_rvalid_i = 1'b1;
    cyc();
    bus.mem_rvalid_i = 1'b0;
  endtask

  task automatic test_routing();
    do_reset();
    bus.addr_i[1*AddrWidth +: AddrWidth] = 32'h40;
    bus.req_i = 3'b010; bus.we_i = 3'b000; bus.mem_gnt_i = 1'b1;
    #3;
    checks++;
    if (bus.gnt_o !== 3'b010 || bus.mem_addr_o !== 32'h40 || bus.mem_we_o !== 1'b0) begin
      errors++;
      $display("FAIL route_read: gnt=%b addr=%h we=%b, required 010 00000040 0", bus.gnt_o, bus.mem_addr_o, bus.mem_we_o);
    end
    cyc();
    bus.req_i = 3'b001; bus.we_i = 3'b001;
    #3;
    checks++;
    if (bus.gnt_o !== 3'b001 || bus.mem_we_o !== 1'b1) begin
      errors++;
      $display("FAIL route_write: gnt=%b we=%b, required 001 1", bus.gnt_o, bus.mem_we_o);
    end
    cyc();
    bus.req_i = '0; bus.we_i = '0; bus.mem_gnt_i = 1'b0;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 64'hDEAD;
    #3;
    checks++;
    if (bus.rvalid_o !== 3'b010 || bus.rdata_o[1*DataWidth +: DataWidth] !== 64'hDEAD) begin
      errors++;
      $display("FAIL route_resp1: rvalid=%b rdata=%h, required 010 dead", bus.rvalid_o, bus.rdata_o[1*DataWidth +: DataWidth]);
    end
    cyc();
    bus.mem_rdata_i = 64'hBEEF;
    #3;
    checks++;
    if (bus.rvalid_o !== 3'b001) begin
      errors++;
      $display("FAIL route_resp2: rvalid=%b, required 001", bus.rvalid_o);
    end
    cyc();
    bus.mem_rvalid_i = 1'b0;
    #3;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL route_idle: busy=%b, required 0", busy_o);
    end
    cyc();
    set_payload();
  endtask

  task automatic test_stall();
    do_reset();
    bus.req_i = 3'b001; bus.mem_gnt_i = 1'b1;
    cyc();
    bus.mem_gnt_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #3;
      checks++;
      if (bus.mem_req_o !== 1'b1 || bus.gnt_o !== 3'b000 ||
          bus.mem_addr_o !== 32'h1000 || bus.mem_strb_o !== 8'hF0) begin
        errors++;
        $display("FAIL stall_%0d: mem_req=%b gnt=%b addr=%h strb=%h, required 1 000 00001000 f0", k, bus.mem_req_o, bus.gnt_o, bus.mem_addr_o, bus.mem_strb_o);
      end
      cyc();
    end
    bus.req_i = 3'b011; bus.mem_gnt_i = 1'b1;
    #3;
    checks++;
    if (bus.gnt_o !== 3'b010) begin
      errors++;
      $display("FAIL stall_ptr_held: gnt=%b, required 010", bus.gnt_o);
    end
    cyc();
    bus.req_i = '0; bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 64'h4444;
    cyc();
    cyc();
    bus.mem_rvalid_i = 1'b0;
  endtask

  task automatic test_spurious();
    do_reset();
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 64'h5555;
    #3;
    checks++;
    if (bus.rvalid_o !== 3'b000 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL spur_same_cycle: rvalid=%b err=%b, required 000 0", bus.rvalid_o, err_o);
    end
    cyc();
    bus.mem_rvalid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.req_i = (k == 1) ? 3'b100 : 3'b000;
      bus.mem_gnt_i = (k == 1);
      bus.mem_rvalid_i = (k == 2);
      #3;
      checks++;
      if (err_o !== 1'b1) begin
        errors++;
        $display("FAIL spur_sticky_%0d: err=%b, required 1", k, err_o);
      end
      cyc();
    end
    bus.req_i = '0; bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0;
    rst_i = 1'b1;
    #3;
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL spur_clear: err=%b, required 0", err_o);
    end
    cyc();
    cyc();
    rst_i = 1'b0;
    cyc();
  endtask

  initial begin
    rst_i            = 1'b1;
    bus.req_i        = '0;
    bus.we_i         = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    set_payload();
    #1;
    test_reset();
    test_fairness();
    test_backpressure();
    test_routing();
    test_stall();
    test_spurious();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
